// File: rtl/gray2rgb_serializer_if.sv
// gray2rgb_serializer_if: gray pixel input stream and serial colour component output stream
interface gray2rgb_serializer_if #(
    parameter int COLOR_SIZE = 8,
    parameter int COUNT_SIZE = 16
);
    logic [COLOR_SIZE-1:0] GrayColor_i;
    logic                  GrayValid_i;
    logic                  GrayReady_o;
    logic [COLOR_SIZE+1:0] RgbColor_o;
    logic                  RgbValid_o;
    logic                  RgbReady_i;
    logic [1:0]            ComponentIdx_o;
    logic                  PixelLast_o;
    logic [COUNT_SIZE-1:0] PixelCount_o;
    modport master (
        output GrayColor_i, GrayValid_i, RgbReady_i,
        input  GrayReady_o, RgbColor_o, RgbValid_o, ComponentIdx_o, PixelLast_o, PixelCount_o
    );
    modport slave (
        input  GrayColor_i, GrayValid_i, RgbReady_i,
        output GrayReady_o, RgbColor_o, RgbValid_o, ComponentIdx_o, PixelLast_o, PixelCount_o
    );
endinterface

// File: rtl/gray2rgb_serializer.sv
// gray2rgb_serializer: replicates each gray pixel as zero-extended R, G, B components, one per transfer
module gray2rgb_serializer #(
    parameter int COLOR_SIZE = 8,
    parameter int COUNT_SIZE = 16
) (
    input logic                 clk_i,
    input logic                 rst_i,
    input logic                 clear_i,
    gray2rgb_serializer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SEND_R, SEND_G, SEND_B} state_t;
    state_t                state_q, state_d;
    logic [COLOR_SIZE-1:0] hold_q, hold_d;
    logic [COUNT_SIZE-1:0] count_q, count_d;
    logic                  busy, in_xfer, out_xfer;
    always_comb begin
        busy = state_q != IDLE;
        bus.GrayReady_o = !rst_i && !clear_i && (state_q == IDLE || (state_q == SEND_B && bus.RgbReady_i));
        in_xfer = bus.GrayValid_i && bus.GrayReady_o;
        out_xfer = busy && bus.RgbReady_i;
        // a new pixel accepted in SEND_B chains straight into SEND_R without an idle bubble
        state_d = in_xfer ? SEND_R : !out_xfer ? state_q : state_q == SEND_B ? IDLE : state_t'(state_q + 2'd1);
        hold_d = in_xfer ? bus.GrayColor_i : hold_q;
        count_d = out_xfer && state_q == SEND_B ? count_q + COUNT_SIZE'(1) : count_q;
        bus.RgbValid_o = busy;
        bus.RgbColor_o = busy ? {2'b00, hold_q} : '0;
        bus.ComponentIdx_o = busy ? state_q - 2'd1 : 2'd0;
        bus.PixelLast_o = state_q == SEND_B;
        bus.PixelCount_o = count_q;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q <= IDLE;
            hold_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            count_q <= count_d;
        end
    end
endmodule
